// File: rtl/adc_spi_responder.sv
// Behavioural SPI target standing in for the ADC configuration port.
// Oversamples mode-0 SPI pins, holds a 16-bit register file, answers reads on miso.
module adc_spi_responder #(
  parameter int          REG_DEPTH   = 32,
  parameter logic [15:0] RESET_VAL   = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk200m,
  input  logic        rst,
  input  logic        adc_sclk,
  input  logic        adc_sen,
  input  logic        adc_mosi,
  input  logic        adc_rst,
  output logic        adc_miso,
  output logic        miso_oe,
  output logic        wr_stb,
  output logic [6:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int         AW    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [7:0] DEPTH = 8'(REG_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, DATA, TAIL} state_t;
  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, sen_sync, mosi_sync, arst_sync;
  logic [15:0] regs [REG_DEPTH];
  logic [14:0] shift_in;
  logic [15:0] shift_out;
  logic [4:0]  bit_cnt;
  logic        rw;
  logic [6:0]  addr;
  logic        tail_err_seen;

  logic sclk_rise, sclk_fall, sen_rise, sen_fall, mosi_s, soft_rst;
  logic shift_en, cmd_done, commit, abort, frame_done, tail_rise;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_rd_data, wdata;

  // sen idles high, so its synchronizer resets to 1 to avoid a phantom frame start
  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      sen_sync  <= '1;
      mosi_sync <= '0;
      arst_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
      sen_sync  <= {sen_sync[SYNC_STAGES-2:0], adc_sen};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], adc_mosi};
      arst_sync <= {arst_sync[SYNC_STAGES-2:0], adc_rst};
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
  assign sen_rise  = sen_sync[SYNC_STAGES-2] & ~sen_sync[SYNC_STAGES-1];
  assign sen_fall  = ~sen_sync[SYNC_STAGES-2] & sen_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign soft_rst  = arst_sync[SYNC_STAGES-1];

  assign cmd_rw      = shift_in[6];
  assign cmd_addr    = {shift_in[5:0], mosi_s};
  assign cmd_rd_data = ({1'b0, cmd_addr} < DEPTH) ? regs[cmd_addr[AW-1:0]] : 16'h0000;
  assign wdata       = {shift_in[14:0], mosi_s};
  assign busy        = (state != IDLE);

  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // sen rise outranks a coincident sclk edge in every active state
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    cmd_done   = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    frame_done = 1'b0;
    tail_rise  = 1'b0;
    if (soft_rst) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (sen_fall) next_state = CMD;
        CMD: begin
          if (sen_rise) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else if (sclk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == 5'd7) begin
              cmd_done   = 1'b1;
              next_state = DATA;
            end
          end
        end
        DATA: begin
          if (sen_rise) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else if (sclk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == 5'd23) begin
              commit     = 1'b1;
              next_state = TAIL;
            end
          end
        end
        TAIL: begin
          if (sen_rise) begin
            frame_done = 1'b1;
            next_state = IDLE;
          end else if (sclk_rise) begin
            tail_rise = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= RESET_VAL;
      shift_in      <= '0;
      shift_out     <= '0;
      bit_cnt       <= '0;
      rw            <= 1'b0;
      addr          <= '0;
      tail_err_seen <= 1'b0;
      adc_miso      <= 1'b0;
      miso_oe       <= 1'b0;
      wr_stb        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      if (soft_rst) begin
        for (int i = 0; i < REG_DEPTH; i++) regs[i] <= RESET_VAL;
        bit_cnt       <= '0;
        tail_err_seen <= 1'b0;
        adc_miso      <= 1'b0;
        miso_oe       <= 1'b0;
      end else begin
        if (state == IDLE && sen_fall) begin
          bit_cnt       <= '0;
          tail_err_seen <= 1'b0;
        end
        if (shift_en) begin
          shift_in <= {shift_in[13:0], mosi_s};
          bit_cnt  <= bit_cnt + 5'd1;
        end
        if (cmd_done) begin
          rw        <= cmd_rw;
          addr      <= cmd_addr;
          shift_out <= cmd_rd_data;
        end
        // out-of-range writes complete the frame but touch nothing
        if (commit && !rw && ({1'b0, addr} < DEPTH)) begin
          regs[addr[AW-1:0]] <= wdata;
          wr_stb             <= 1'b1;
          wr_addr            <= addr;
          wr_data            <= wdata;
        end
        if (state == DATA && rw && sclk_fall && !sen_rise) begin
          adc_miso  <= shift_out[15];
          shift_out <= {shift_out[14:0], 1'b0};
          miso_oe   <= 1'b1;
        end
        if (abort || frame_done) begin
          adc_miso <= 1'b0;
          miso_oe  <= 1'b0;
        end
        if (abort) frame_err <= 1'b1;
        if (frame_done) frame_cnt <= frame_cnt + 16'd1;
        if (tail_rise && !tail_err_seen) begin
          frame_err     <= 1'b1;
          tail_err_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bit-bangs SPI frames from the initiator side
// and checks register file behaviour, strobes, errors and frame counting.
module tb_adc_spi_responder;

  logic        clk200m = 1'b0;
  logic        rst = 1'b1;
  logic        adc_sclk = 1'b0;
  logic        adc_sen = 1'b1;
  logic        adc_mosi = 1'b0;
  logic        adc_rst = 1'b0;
  logic        adc_miso, miso_oe, wr_stb, frame_err, busy;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data, frame_cnt;

  int compared = 0;
  int mismatched = 0;
  int wr_stb_seen = 0;
  int frame_err_seen = 0;

  logic [15:0] rd_word;
  int          oe_cnt;
  logic        snap_busy;
  logic [1:0]  snap_pre;
  logic [43:0] snap_out;

  adc_spi_responder #(.REG_DEPTH(32), .RESET_VAL(16'h0000), .SYNC_STAGES(2)) dut (
    .clk200m(clk200m), .rst(rst), .adc_sclk(adc_sclk), .adc_sen(adc_sen),
    .adc_mosi(adc_mosi), .adc_rst(adc_rst), .adc_miso(adc_miso), .miso_oe(miso_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk200m = ~clk200m;

  always @(negedge clk200m) begin
    if (wr_stb === 1'b1) wr_stb_seen++;
    if (frame_err === 1'b1) frame_err_seen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk200m);
    rst = 1'b1; adc_sen = 1'b1; adc_sclk = 1'b0; adc_mosi = 1'b0; adc_rst = 1'b0;
    repeat (4) @(negedge clk200m);
    rst = 1'b0;
    repeat (4) @(negedge clk200m);
  endtask

  // mode 1 pulses adc_rst before bit evt_bit; mode 2 pulses rst there and ends the frame
  task automatic spi_frame(input logic [23:0] word, input int nbits, input int mode,
                           input int evt_bit, output logic [15:0] rd, output int oe);
    rd = 16'h0000;
    oe = 0;
    @(negedge clk200m);
    adc_sen = 1'b0;
    repeat (8) @(negedge clk200m);
    for (int i = 0; i < nbits; i++) begin
      if (mode == 1 && i == evt_bit) begin
        adc_rst = 1'b1;
        repeat (10) @(negedge clk200m);
        snap_busy = busy;
        adc_rst = 1'b0;
        repeat (4) @(negedge clk200m);
      end
      if (mode == 2 && i == evt_bit) begin
        snap_pre = {miso_oe, busy};
        rst = 1'b1;
        #1;
        snap_out = {adc_miso, miso_oe, wr_stb, frame_err, busy, wr_addr, wr_data, frame_cnt};
        adc_sen = 1'b1;
        adc_sclk = 1'b0;
        repeat (4) @(negedge clk200m);
        rst = 1'b0;
        repeat (4) @(negedge clk200m);
        break;
      end
      adc_mosi = (i < 24) ? word[23-i] : 1'b0;
      repeat (8) @(negedge clk200m);
      if (i >= 8 && i < 24) begin
        rd[23-i] = adc_miso;
        if (miso_oe === 1'b1) oe++;
      end
      adc_sclk = 1'b1;
      repeat (8) @(negedge clk200m);
      adc_sclk = 1'b0;
    end
    if (mode != 2) begin
      repeat (8) @(negedge clk200m);
      adc_sen = 1'b1;
      adc_mosi = 1'b0;
      repeat (12) @(negedge clk200m);
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({adc_miso, miso_oe, wr_stb, frame_err, busy} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {adc_miso, miso_oe, wr_stb, frame_err, busy});
    end
    compared++;
    if ({wr_addr, wr_data, frame_cnt} !== 39'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: wr_addr %h wr_data %h frame_cnt %h expected all 0", wr_addr, wr_data, frame_cnt);
    end
  endtask

  task automatic test_write_read();
    int w0, e0;
    do_reset();
    w0 = wr_stb_seen; e0 = frame_err_seen;
    spi_frame({1'b0, 7'h05, 16'hA5C3}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (wr_stb_seen - w0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL wr_read_stb_count: got %0d expected 1", wr_stb_seen - w0);
    end
    compared++;
    if ({wr_addr, wr_data} !== {7'h05, 16'hA5C3}) begin
      mismatched++;
      $display("[TB] FAIL wr_read_last_write: got %h/%h expected 05/a5c3", wr_addr, wr_data);
    end
    spi_frame({1'b1, 7'h05, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'hA5C3) begin
      mismatched++;
      $display("[TB] FAIL wr_read_data: got %h expected a5c3", rd_word);
    end
    compared++;
    if (oe_cnt !== 16) begin
      mismatched++;
      $display("[TB] FAIL wr_read_oe_bits: got %0d expected 16", oe_cnt);
    end
    compared++;
    if (frame_cnt !== 16'd2) begin
      mismatched++;
      $display("[TB] FAIL wr_read_frame_cnt: got %0d expected 2", frame_cnt);
    end
    compared++;
    if ({frame_err_seen - e0, miso_oe, adc_miso, busy} !== {32'd0, 3'b000}) begin
      mismatched++;
      $display("[TB] FAIL wr_read_idle: errs %0d oe %b miso %b busy %b expected 0 0 0 0",
               frame_err_seen - e0, miso_oe, adc_miso, busy);
    end
  endtask

  task automatic test_out_of_range();
    int w0;
    do_reset();
    spi_frame({1'b0, 7'h00, 16'h7777}, 24, 0, 0, rd_word, oe_cnt);
    w0 = wr_stb_seen;
    spi_frame({1'b0, 7'h40, 16'h1234}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (wr_stb_seen - w0 !== 0 || wr_data !== 16'h7777) begin
      mismatched++;
      $display("[TB] FAIL oor_write_dropped: strobes %0d wr_data %h expected 0 / 7777", wr_stb_seen - w0, wr_data);
    end
    spi_frame({1'b1, 7'h40, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL oor_read_zero: got %h expected 0000", rd_word);
    end
    spi_frame({1'b1, 7'h00, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h7777) begin
      mismatched++;
      $display("[TB] FAIL oor_no_alias: got %h expected 7777", rd_word);
    end
    compared++;
    if (frame_cnt !== 16'd4) begin
      mismatched++;
      $display("[TB] FAIL oor_frame_cnt: got %0d expected 4", frame_cnt);
    end
  endtask

  task automatic test_abort();
    int w0, e0;
    do_reset();
    spi_frame({1'b0, 7'h03, 16'h1111}, 24, 0, 0, rd_word, oe_cnt);
    w0 = wr_stb_seen; e0 = frame_err_seen;
    spi_frame({1'b0, 7'h03, 16'h2222}, 12, 0, 0, rd_word, oe_cnt);
    compared++;
    if (frame_err_seen - e0 !== 1 || wr_stb_seen - w0 !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_pulses: frame_err %0d wr_stb %0d expected 1 / 0", frame_err_seen - e0, wr_stb_seen - w0);
    end
    compared++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_state: frame_cnt %0d busy %b expected 1 / 0", frame_cnt, busy);
    end
    spi_frame({1'b1, 7'h03, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h1111) begin
      mismatched++;
      $display("[TB] FAIL abort_reg_kept: got %h expected 1111", rd_word);
    end
  endtask

  task automatic test_overlong();
    int w0, e0;
    do_reset();
    w0 = wr_stb_seen; e0 = frame_err_seen;
    spi_frame({1'b0, 7'h02, 16'hBEEF}, 26, 0, 0, rd_word, oe_cnt);
    compared++;
    if (frame_err_seen - e0 !== 1 || wr_stb_seen - w0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL overlong_pulses: frame_err %0d wr_stb %0d expected 1 / 1", frame_err_seen - e0, wr_stb_seen - w0);
    end
    compared++;
    if (frame_cnt !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL overlong_frame_cnt: got %0d expected 1", frame_cnt);
    end
    e0 = frame_err_seen;
    spi_frame({1'b1, 7'h02, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'hBEEF || frame_err_seen - e0 !== 0) begin
      mismatched++;
      $display("[TB] FAIL overlong_readback: got %h errs %0d expected beef / 0", rd_word, frame_err_seen - e0);
    end
  endtask

  task automatic test_soft_reset();
    int w0, e0;
    do_reset();
    spi_frame({1'b0, 7'h01, 16'hFFFF}, 24, 0, 0, rd_word, oe_cnt);
    @(negedge clk200m);
    adc_rst = 1'b1;
    repeat (10) @(negedge clk200m);
    adc_rst = 1'b0;
    repeat (6) @(negedge clk200m);
    spi_frame({1'b1, 7'h01, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL soft_rst_clears: got %h expected 0000", rd_word);
    end
    w0 = wr_stb_seen; e0 = frame_err_seen;
    spi_frame({1'b0, 7'h01, 16'h5555}, 24, 1, 20, rd_word, oe_cnt);
    compared++;
    if (snap_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL soft_rst_midframe_busy: got %b expected 0", snap_busy);
    end
    compared++;
    if (wr_stb_seen - w0 !== 0 || frame_err_seen - e0 !== 0 || frame_cnt !== 16'd2) begin
      mismatched++;
      $display("[TB] FAIL soft_rst_midframe_quiet: wr_stb %0d frame_err %0d frame_cnt %0d expected 0 / 0 / 2",
               wr_stb_seen - w0, frame_err_seen - e0, frame_cnt);
    end
    spi_frame({1'b1, 7'h01, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h0000 || frame_cnt !== 16'd3) begin
      mismatched++;
      $display("[TB] FAIL soft_rst_no_write: got %h cnt %0d expected 0000 / 3", rd_word, frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    spi_frame({1'b0, 7'h04, 16'hFFFF}, 24, 0, 0, rd_word, oe_cnt);
    spi_frame({1'b1, 7'h04, 16'h0000}, 24, 2, 15, rd_word, oe_cnt);
    compared++;
    if (snap_pre !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL async_rst_pre_active: oe/busy %b expected 11", snap_pre);
    end
    compared++;
    if (snap_out !== 44'h0) begin
      mismatched++;
      $display("[TB] FAIL async_rst_outputs: got %h expected 0", snap_out);
    end
    spi_frame({1'b1, 7'h04, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h0000 || oe_cnt !== 16 || frame_cnt !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL async_rst_recover: data %h oe %0d cnt %0d expected 0000 / 16 / 1", rd_word, oe_cnt, frame_cnt);
    end
    spi_frame({1'b0, 7'h06, 16'h1357}, 24, 0, 0, rd_word, oe_cnt);
    spi_frame({1'b1, 7'h06, 16'h0000}, 24, 0, 0, rd_word, oe_cnt);
    compared++;
    if (rd_word !== 16'h1357 || frame_cnt !== 16'd3) begin
      mismatched++;
      $display("[TB] FAIL async_rst_after_write: data %h cnt %0d expected 1357 / 3", rd_word, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_abort();
    test_overlong();
    test_soft_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Behavioural SPI target that models the ADC configuration port. It sits on the far end of the adc_sclk/adc_sen/adc_mosi/adc_miso wires driven by the ADC interface's SPI initiator.
- Used in loopback builds and benches to close the config path without silicon. Lets the SPI initiator's write/readback flow and the auto-seek restart flow be exercised in hardware.
- Holds a 16-bit register file, applies writes, returns reads on miso, and reports frame events and errors.
- All logic runs in one fast clock; SPI pins are oversampled. Single clock domain except the pin synchronizers.

Parameters:
- REG_DEPTH, 32: number of 16-bit registers; addresses 0..REG_DEPTH-1 are valid; must be a power of 2, ≤128.
- RESET_VAL, 16'h0000: value loaded into every register on reset or soft reset.
- SYNC_STAGES, 2: synchronizer depth on sclk/sen/mosi, ≥2.

Ports:
- clk200m  in  1  Oversampling clock, 200 MHz; sclk ≤ clk200m/8.
- rst  in  1  Asynchronous, active-high reset.
- adc_sclk  in  1  SPI clock from initiator, idle low, mode 0.
- adc_sen  in  1  Chip enable, active low.
- adc_mosi  in  1  Serial data in, MSB first.
- adc_rst  in  1  ADC hard-reset pin, active high, level-sensitive soft reset of the register file.
- adc_miso  out  1  Serial read data.
- miso_oe  out  1  High while the responder drives adc_miso (read data phase).
- wr_stb  out  1  One-cycle pulse when a write commits.
- wr_addr  out  7  Address of the last committed write.
- wr_data  out  16  Data of the last committed write.
- frame_err  out  1  One-cycle pulse on an aborted or overlong frame.
- frame_cnt  out  16  Count of completed frames (read + write), wraps.
- busy  out  1  High while in any state other than IDLE.

Behaviour:
- Frame format: 24 bits, MSB first. Bit 23 = R/W (1 = read). Bits 22:16 = addr[6:0]. Bits 15:0 = data; for reads, data bits from mosi are ignored.
- Synchronization: sclk, sen and mosi each pass through SYNC_STAGES flops. The sclk edge detect is taken from the last two synchronized stages.
  - Rise event: sample mosi.
  - Fall event: shift miso.
  - All decisions use synchronized values; latency is SYNC_STAGES+1 cycles from pin to action.
- FSM states: IDLE, CMD, DATA, TAIL.
  - IDLE → CMD on synchronized sen falling. Bit counter is cleared to 0 on entry.
  - CMD: shift 8 bits on rise events. At the 8th rise, latch rw/addr.
    - For a read, load shift_out with reg[addr] (0 if addr ≥ REG_DEPTH), then go to DATA.
  - DATA: shift 16 bits.
    - Read: on each fall event, drive adc_miso = shift_out[15], then shift left. miso_oe is 1 from the first fall after bit 8 until the frame ends.
    - Write: at the 24th rise, if addr < REG_DEPTH then reg[addr] ← data and pulse wr_stb the next cycle; out-of-range writes are dropped with no wr_stb. Update wr_addr/wr_data with wr_stb.
    - Then go to TAIL.
  - TAIL: wait for sen rising → IDLE, frame_cnt+1.
    - Any rise event in TAIL → frame_err pulse once per frame; the frame still counts.
- Abort: sen rising in CMD or DATA (fewer than 24 bits) → IDLE, frame_err pulse, no register write, frame_cnt unchanged.
- Read-after-write: a read frame immediately following a write returns the new value; the write commits before the next frame's 8th rise.
- adc_rst high: all registers ← RESET_VAL and FSM forced to IDLE; no frame_err, no count. Frames are ignored while adc_rst is high.
- Reset (rst): registers ← RESET_VAL, FSM IDLE, adc_miso 0, miso_oe 0, wr_stb 0, wr_addr 0, wr_data 0, frame_err 0, frame_cnt 0, busy 0.
- Simultaneous events: a synchronized sen rise and an sclk rise in the same cycle are treated as sen first (abort/end), and the sclk edge is ignored. adc_miso returns to 0 and miso_oe to 0 in the cycle sen rise is seen.
- frame_cnt wraps 16'hFFFF → 0.

Test Plan:
- Write then read: write addr 7'h05 data 16'hA5C3, then read addr 5 → wr_stb once with wr_addr=5, wr_data=A5C3; miso returns A5C3 MSB first, miso_oe high for 16 bits; frame_cnt=2.
- Out-of-range access (REG_DEPTH=32): write addr 7'h40 data 16'h1234 → no wr_stb; read addr 7'h40 → 16'h0000; frame_cnt=2.
- Abort: sen deasserted after 12 bits of a write to addr 3 → frame_err pulse, reg[3] unchanged, frame_cnt unchanged, busy 0.
- Overlong frame: write of 26 clocks to addr 2 data 16'hBEEF → reg[2]=BEEF, one frame_err pulse, frame_cnt+1.
- Soft reset: write 16'hFFFF to addr 1, pulse adc_rst, then read addr 1 → RESET_VAL. Asserting adc_rst mid-frame → FSM IDLE, no write.
- Async reset mid-read (rst pulse at bit 15) → all outputs at reset values immediately. Next full read frame works; frame_cnt counts from 0.
